alu_control_sequencer: RTL

//  Hardwired control unit directly upstream of Datapath. Fetches an instruction, decodes IR
//  and drives the one-hot datapath strobes for register-register ALU instructions, one T-state
//  per Clock. Replaces the hand-written stimulus currently used to exercise Datapath.

---
 rtl/cpu_pkg.sv | 83 ++++++++
 rtl/reg_select_decoder.sv | 20 ++
 rtl/alu_control_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the ALU control sequencer: opcodes, ALU codes, state
// encoding and instruction-register field positions.
package cpu_pkg;

    localparam int OPC_HI = 31;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;
    localparam logic [4:0] OP_SHL = 5'b01000;
    localparam logic [4:0] OP_ROR = 5'b01001;
    localparam logic [4:0] OP_ROL = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SHR = 5'b00100;
    localparam logic [4:0] ALU_SHL = 5'b00101;
    localparam logic [4:0] ALU_ROR = 5'b00110;
    localparam logic [4:0] ALU_ROL = 5'b00111;
    localparam logic [4:0] ALU_MUL = 5'b01000;
    localparam logic [4:0] ALU_DIV = 5'b01001;
    localparam logic [4:0] ALU_NEG = 5'b01010;
    localparam logic [4:0] ALU_NOT = 5'b01011;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        K_BIN     = 2'd0,
        K_MULDIV  = 2'd1,
        K_UNARY   = 2'd2,
        K_ILLEGAL = 2'd3
    } op_kind_t;

    typedef struct packed {
        op_kind_t   kind;
        logic [4:0] alu;
    } op_dec_t;

    function automatic op_dec_t decode_op(input logic [4:0] opc);
        op_dec_t d;
        case (opc)
            OP_ADD:  d = '{K_BIN,     ALU_ADD};
            OP_SUB:  d = '{K_BIN,     ALU_SUB};
            OP_AND:  d = '{K_BIN,     ALU_AND};
            OP_OR:   d = '{K_BIN,     ALU_OR};
            OP_SHR:  d = '{K_BIN,     ALU_SHR};
            OP_SHL:  d = '{K_BIN,     ALU_SHL};
            OP_ROR:  d = '{K_BIN,     ALU_ROR};
            OP_ROL:  d = '{K_BIN,     ALU_ROL};
            OP_MUL:  d = '{K_MULDIV,  ALU_MUL};
            OP_DIV:  d = '{K_MULDIV,  ALU_DIV};
            OP_NEG:  d = '{K_UNARY,   ALU_NEG};
            OP_NOT:  d = '{K_UNARY,   ALU_NOT};
            default: d = '{K_ILLEGAL, 5'b00000};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Turns a register field plus an enable into a one-hot register select vector.
module reg_select_decoder #(
    parameter int NREG  = 16,
    parameter int SEL_W = $clog2(NREG)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [NREG-1:0]  onehot
);

    // One-hot decode, all zeros when not enabled.
    always_comb begin
        if (en) begin
            onehot = {{(NREG-1){1'b0}}, 1'b1} << sel;
        end else begin
            onehot = {NREG{1'b0}};
        end
    end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/decode/execute control unit driving Datapath strobes for
// register-register ALU instructions, one T-state per clock.
module alu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int NREG  = 16,
    parameter int OPC_W = 5
) (
    input  logic            Clock,
    input  logic            Clear,
    input  logic            Run,
    input  logic            Mem_Ready,
    input  logic [31:0]     IR_Value,
    output logic            PC_Out,
    output logic            MDR_Out,
    output logic            ZLO_Out,
    output logic            ZHI_Out,
    output logic            PC_In,
    output logic            MDR_In,
    output logic            MAR_In,
    output logic            IR_In,
    output logic            Y_In,
    output logic            ZLO_In,
    output logic            ZHI_In,
    output logic            LO_In,
    output logic            HI_In,
    output logic            IncPC,
    output logic            Read,
    output logic [4:0]      CONTROL,
    output logic [NREG-1:0] Rin,
    output logic [NREG-1:0] Rout,
    output logic            Done,
    output logic            Fault
);

    state_t         state_q, state_d;
    op_dec_t        dec_s;
    logic [3:0]     ra_s, rb_s, rc_s;
    logic [3:0]     rout_sel_s;
    logic           rout_en_s, rin_en_s;
    logic           unused_ir_bits;
    state_t         end_next_s;

    assign dec_s          = decode_op(IR_Value[OPC_HI -: OPC_W]);
    assign ra_s           = IR_Value[RA_HI:RA_LO];
    assign rb_s           = IR_Value[RB_HI:RB_LO];
    assign rc_s           = IR_Value[RC_HI:RC_LO];
    assign unused_ir_bits = ^IR_Value[RC_LO-1:0];
    assign end_next_s     = Run ? S_T0 : S_IDLE;

    // State register; Clear aborts to IDLE from any state.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = Run ? S_T0 : S_IDLE;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = Mem_Ready ? S_T2 : S_T1;
            S_T2:   state_d = S_T3;
            S_T3:   state_d = (dec_s.kind == K_ILLEGAL) ? S_HALT : S_T4;
            S_T4:   state_d = (dec_s.kind == K_UNARY) ? end_next_s : S_T5;
            S_T5:   state_d = (dec_s.kind == K_MULDIV) ? S_T6 : end_next_s;
            S_T6:   state_d = end_next_s;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobe decode from state and IR fields; illegal opcodes emit nothing at T3.
    always_comb begin
        PC_Out = 1'b0; MDR_Out = 1'b0; ZLO_Out = 1'b0; ZHI_Out = 1'b0;
        PC_In = 1'b0; MDR_In = 1'b0; MAR_In = 1'b0; IR_In = 1'b0;
        Y_In = 1'b0; ZLO_In = 1'b0; ZHI_In = 1'b0; LO_In = 1'b0; HI_In = 1'b0;
        IncPC = 1'b0; Read = 1'b0; CONTROL = 5'b00000; Done = 1'b0; Fault = 1'b0;
        rout_en_s = 1'b0; rout_sel_s = rb_s; rin_en_s = 1'b0;
        case (state_q)
            S_T0: begin
                PC_Out = 1'b1; MAR_In = 1'b1; IncPC = 1'b1; ZLO_In = 1'b1;
            end
            S_T1: begin
                ZLO_Out = 1'b1; Read = 1'b1; MDR_In = 1'b1; PC_In = Mem_Ready;
            end
            S_T2: begin
                MDR_Out = 1'b1; IR_In = 1'b1;
            end
            S_T3: begin
                case (dec_s.kind)
                    K_BIN, K_MULDIV: begin
                        rout_en_s = 1'b1; Y_In = 1'b1;
                    end
                    K_UNARY: begin
                        rout_en_s = 1'b1; CONTROL = dec_s.alu; ZLO_In = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (dec_s.kind)
                    K_BIN, K_MULDIV: begin
                        rout_en_s = 1'b1; rout_sel_s = rc_s; CONTROL = dec_s.alu;
                        ZLO_In = 1'b1; ZHI_In = (dec_s.kind == K_MULDIV);
                    end
                    K_UNARY: begin
                        ZLO_Out = 1'b1; rin_en_s = 1'b1; Done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (dec_s.kind)
                    K_MULDIV: begin
                        ZLO_Out = 1'b1; LO_In = 1'b1;
                    end
                    K_BIN: begin
                        ZLO_Out = 1'b1; rin_en_s = 1'b1; Done = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                ZHI_Out = 1'b1; HI_In = 1'b1; Done = 1'b1;
            end
            S_HALT: Fault = 1'b1;
            default: ;
        endcase
    end

    reg_select_decoder #(.NREG(NREG)) u_rout_dec (
        .sel    (rout_sel_s),
        .en     (rout_en_s),
        .onehot (Rout)
    );

    reg_select_decoder #(.NREG(NREG)) u_rin_dec (
        .sel    (ra_s),
        .en     (rin_en_s),
        .onehot (Rin)
    );

endmodule
